// File: rtl/cpu_move_gen_if.sv
// cpu_move_gen_if: move request/response handshake between game engine (master) and CPU move generator (slave).
interface cpu_move_gen_if;
  logic        req_valid;
  logic        req_ready;
  logic [17:0] board_flat;
  logic        cpu_player;
  logic        move_valid;
  logic        move_ready;
  logic [8:0]  move_onehot;
  logic [3:0]  move_index;
  logic        no_move;
  logic        busy;
  modport master (output req_valid, board_flat, cpu_player, move_ready,
                  input req_ready, move_valid, move_onehot, move_index, no_move, busy);
  modport slave (input req_valid, board_flat, cpu_player, move_ready,
                 output req_ready, move_valid, move_onehot, move_index, no_move, busy);
endinterface

// File: rtl/cpu_move_gen.sv
// cpu_move_gen: tic-tac-toe CPU opponent (win, block, centre, corners, edges); CPU_RANDOM_EN adds LFSR-rotated corner/edge order.
module cpu_move_gen #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic MAX10_CLK1_50,
  input logic rst,
  cpu_move_gen_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SCAN_WIN, SCAN_BLOCK, PICK, RESP} state_t;
  localparam logic [95:0] LINES = {4'd6, 4'd4, 4'd2, 4'd8, 4'd4, 4'd0, 4'd8, 4'd5, 4'd2, 4'd7, 4'd4, 4'd1,
                                   4'd6, 4'd3, 4'd0, 4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
  localparam logic [15:0] CORNERS = {4'd8, 4'd6, 4'd2, 4'd0};
  localparam logic [15:0] EDGES = {4'd7, 4'd5, 4'd3, 4'd1};
  state_t state_q, state_d;
  logic [2:0] k_q, k_d;
  logic [3:0] tgt_q, tgt_d;
  logic valid_q, valid_d;
  logic [17:0] board_q, board_d;
  logic cp_q, cp_d;
  logic [1:0] r;
  logic accept;
  logic [11:0] ln;
  logic [3:0] a [3];
  logic [2:0] m, e;
  logic [1:0] code;
  logic hit;
  logic [3:0] line_tgt, pick;
  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] i);
    return b[{i, 1'b0} +: 2];
  endfunction
  function automatic logic [3:0] ord(input int i, input logic [1:0] rot);
    logic [1:0] p;
    p = 2'(i - 1) + rot;
    return i == 0 ? 4'd4 : i < 5 ? CORNERS[{p, 2'b0} +: 4] : EDGES[{p, 2'b0} +: 4];
  endfunction
  assign accept = state_q == IDLE && bus.req_valid;
`ifdef CPU_RANDOM_EN
  logic [15:0] lfsr_q;
  logic [1:0] r_q;
  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
      r_q <= 2'd0;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      r_q <= accept ? lfsr_q[1:0] : r_q;
    end
  end
  assign r = r_q;
`else
  logic unused_seed;
  assign unused_seed = ^LFSR_SEED;
  assign r = 2'd0;
`endif
  // Line k hits when the two non-empty cells carry the scanned code and the third is empty.
  always_comb begin
    ln = LINES[int'(k_q) * 12 +: 12];
    code = (cp_q ^ (state_q == SCAN_BLOCK)) ? 2'b10 : 2'b01;
    for (int j = 0; j < 3; j++) begin
      a[j] = ln[4 * j +: 4];
      m[j] = cell_of(board_q, a[j]) == code;
      e[j] = cell_of(board_q, a[j]) == 2'b00;
    end
    hit = (m | e) == 3'b111 && $onehot(e);
    line_tgt = e[0] ? a[0] : e[1] ? a[1] : a[2];
    pick = 4'hF;
    for (int i = 8; i >= 0; i--)
      pick = cell_of(board_q, ord(i, r)) == 2'b00 ? ord(i, r) : pick;
  end
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    tgt_d = tgt_q;
    board_d = board_q;
    cp_d = cp_q;
    valid_d = state_q == RESP && !(valid_q && bus.move_ready);
    case (state_q)
      IDLE: if (accept) begin
        board_d = bus.board_flat;
        cp_d = bus.cpu_player;
        k_d = 3'd0;
        state_d = SCAN_WIN;
      end
      SCAN_WIN, SCAN_BLOCK: begin
        k_d = k_q + 3'd1;
        tgt_d = hit ? line_tgt : tgt_q;
        state_d = hit ? RESP : k_q != 3'd7 ? state_q : state_q == SCAN_WIN ? SCAN_BLOCK : PICK;
      end
      PICK: begin
        tgt_d = pick;
        state_d = RESP;
      end
      RESP: state_d = (valid_q && bus.move_ready) ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge MAX10_CLK1_50) begin
    if (rst) begin
      state_q <= IDLE;
      k_q <= 3'd0;
      tgt_q <= 4'hF;
      valid_q <= 1'b0;
      board_q <= '0;
      cp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      tgt_q <= tgt_d;
      valid_q <= valid_d;
      board_q <= board_d;
      cp_q <= cp_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.busy = state_q != IDLE;
  assign bus.move_valid = valid_q;
  assign bus.move_index = valid_q ? tgt_q : 4'hF;
  assign bus.no_move = valid_q && tgt_q == 4'hF;
  assign bus.move_onehot = (valid_q && tgt_q != 4'hF) ? 9'(1) << tgt_q : 9'd0;
endmodule

// File: tb/tb_cpu_move_gen.sv
// tb_cpu_move_gen: randomized scoreboard bench for cpu_move_gen against a rule-level move model.
module tb_cpu_move_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  cpu_move_gen_if bus();
  cpu_move_gen dut (.MAX10_CLK1_50(clk), .rst(rst), .bus(bus));
  typedef struct {logic [3:0] idx; int lat; int t;} exp_t;
  exp_t sb[$];
  exp_t me;
  int tests = 0, fails = 0, cyc = 0;
  bit hold_lo = 0, in_resp = 0, after_hs = 0;
  logic [3:0] h_idx;
  logic [8:0] h_oh;
  logic h_nm;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask
  function automatic void model(input logic [17:0] b, input logic cp, output logic [3:0] idx, output int lat);
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
    int order [9] = '{4, 0, 2, 6, 8, 1, 3, 5, 7};
    for (int ph = 0; ph < 2; ph++) begin
      logic [1:0] c;
      c = (cp ^ ph[0]) ? 2'b10 : 2'b01;
      for (int k = 0; k < 8; k++) begin
        int own = 0, emp = 0, t = 0;
        for (int j = 0; j < 3; j++) begin
          if (b[2 * lines[k][j] +: 2] == c) own++;
          if (b[2 * lines[k][j] +: 2] == 2'b00) begin emp++; t = lines[k][j]; end
        end
        if (own == 2 && emp == 1) begin
          idx = 4'(t);
          lat = 2 + 8 * ph + k;
          return;
        end
      end
    end
    idx = 4'hF;
    lat = 18;
    for (int i = 8; i >= 0; i--)
      if (b[2 * order[i] +: 2] == 2'b00) idx = 4'(order[i]);
  endfunction
  always @(negedge clk) begin
    if (rst) begin
      in_resp = 0;
      after_hs = 0;
    end else begin
      if (after_hs) begin
        chk("ready_after_handshake", 32'(bus.req_ready), 32'd1);
        chk("valid_after_handshake", 32'(bus.move_valid), 32'd0);
        after_hs = 0;
      end
      if (bus.move_valid) begin
        if (!in_resp) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_response: got index %0d expected no response", bus.move_index);
          end else begin
            me = sb.pop_front();
            chk("move_index", 32'(bus.move_index), 32'(me.idx));
            chk("move_onehot", 32'(bus.move_onehot), me.idx == 4'hF ? 32'd0 : 32'd1 << me.idx);
            chk("no_move", 32'(bus.no_move), 32'(me.idx == 4'hF));
            chk("latency", 32'(cyc - me.t), 32'(me.lat));
            chk("ready_in_resp", 32'(bus.req_ready), 32'd0);
            chk("busy_in_resp", 32'(bus.busy), 32'd1);
          end
          in_resp = 1;
          h_idx = bus.move_index;
          h_oh = bus.move_onehot;
          h_nm = bus.no_move;
        end else
          chk("resp_stable", {bus.move_index, bus.move_onehot, bus.no_move}, {h_idx, h_oh, h_nm});
      end
      bus.move_ready = hold_lo ? 1'b0 : ($urandom_range(0, 9) < 7);
      if (bus.move_valid && bus.move_ready) begin
        in_resp = 0;
        after_hs = 1;
      end
    end
  end
  task automatic issue(input logic [17:0] b, input logic cp);
    int w = 0;
    logic [3:0] idx;
    int lat;
    while (bus.req_ready !== 1'b1) begin
      if (w == 200) begin
        tests++;
        fails++;
        $display("FAIL req_ready_timeout: got 0 expected 1 within 200 cycles");
        bus.req_valid = 1'b0;
        return;
      end
      bus.req_valid = 1'($urandom);
      bus.board_flat = 18'($urandom);
      bus.cpu_player = 1'($urandom);
      @(negedge clk);
      w++;
    end
    bus.req_valid = 1'b1;
    bus.board_flat = b;
    bus.cpu_player = cp;
    model(b, cp, idx, lat);
    @(negedge clk);
    sb.push_back('{idx, lat, cyc});
    bus.req_valid = 1'b0;
    bus.board_flat = 18'($urandom);
    bus.cpu_player = 1'($urandom);
  endtask
  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || bus.move_valid || !bus.req_ready) && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w == 100) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask
  task automatic wait_valid();
    int w = 0;
    while (!bus.move_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("valid_wait", 32'(bus.move_valid), 32'd1);
  endtask
  task automatic reset_checks(input string n);
    chk({n, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({n, "_move_valid"}, 32'(bus.move_valid), 32'd0);
    chk({n, "_busy"}, 32'(bus.busy), 32'd0);
    chk({n, "_move_index"}, 32'(bus.move_index), 32'hF);
    chk({n, "_move_onehot"}, 32'(bus.move_onehot), 32'd0);
    chk({n, "_no_move"}, 32'(bus.no_move), 32'd0);
  endtask
  initial begin
    logic [17:0] b;
    bus.req_valid = 1'b0;
    bus.board_flat = '0;
    bus.cpu_player = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst = 1'b0;
    issue(18'b00_00_00_00_00_10_00_01_01, 1'b0);
    issue(18'b00_00_00_00_10_10_00_01_01, 1'b1);
    issue(18'b00_00_00_00_10_10_00_00_01, 1'b0);
    issue(18'd0, 1'b0);
    issue(18'b00_00_00_00_10_00_00_00_00, 1'b0);
    issue(18'h3FFFF, 1'b0);
    issue(18'b01_01_10_10_10_01_01_10_01, 1'b1);
    for (int n = 0; n < 150; n++) begin
      for (int i = 0; i < 9; i++) begin
        int v;
        v = $urandom_range(0, 9);
        b[2 * i +: 2] = v < 4 ? 2'b00 : v < 7 ? 2'b01 : v < 9 ? 2'b10 : 2'b11;
      end
      issue(b, 1'($urandom));
    end
    drain();
    hold_lo = 1;
    issue(18'b00_00_00_00_00_10_00_01_01, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      bus.req_valid = 1'b1;
      bus.board_flat = 18'd0;
      @(negedge clk);
      chk("stall_ready_low", 32'(bus.req_ready), 32'd0);
    end
    bus.req_valid = 1'b0;
    hold_lo = 0;
    drain();
    issue(18'd0, 1'b1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("scan_reset");
    sb.delete();
    rst = 1'b0;
    hold_lo = 1;
    issue(18'b00_00_00_00_10_10_00_00_01, 1'b0);
    wait_valid();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    reset_checks("resp_reset");
    sb.delete();
    rst = 1'b0;
    hold_lo = 0;
    issue(18'b00_00_00_00_00_10_00_01_01, 1'b0);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
